// File: rtl/doorlock_ctrl_if.sv
// Keypad-side bundle for the door lock password sequencer: press pulses in,
// lock status out. The master modport drives the pulses, the slave is the controller.
interface doorlock_ctrl_if;
  logic [9:0] button_on;
  logic       enter;
  logic       clear;
  logic       set_pw;
  logic       unlock;
  logic       error;
  logic       locked;
  logic [3:0] digit_cnt;
  logic [3:0] fail_cnt;

  modport master (
    output button_on, enter, clear, set_pw,
    input  unlock, error, locked, digit_cnt, fail_cnt
  );

  modport slave (
    input  button_on, enter, clear, set_pw,
    output unlock, error, locked, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/doorlock_ctrl.sv
// Door lock password sequencer: collects BCD digits, checks them on enter, drives unlock/error/lockout.
// Optional password change in the open state is enabled by defining PW_CHANGE_EN.
module doorlock_ctrl #(
  parameter int unsigned PW_LEN         = 4,
  parameter logic [31:0] DEFAULT_PW     = 32'h0000_1234,
  parameter logic [15:0] UNLOCK_CYCLES  = 16'd1000,
  parameter int unsigned MAX_FAIL       = 3,
  parameter logic [15:0] LOCKOUT_CYCLES = 16'd5000
) (
  input  logic           clock,
  input  logic           reset,
  doorlock_ctrl_if.slave bus
);
  localparam int unsigned EW         = 4 * PW_LEN;
  localparam logic [3:0]  PW_LEN_C   = 4'(PW_LEN);
  localparam logic [3:0]  MAX_FAIL_C = 4'(MAX_FAIL);
  localparam logic [EW-1:0] PW_RST   = DEFAULT_PW[EW-1:0];

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
`ifdef PW_CHANGE_EN
    ST_LOCKOUT = 3'd4,
    ST_NEWPW   = 3'd5
`else
    ST_LOCKOUT = 3'd4
`endif
  } state_t;

  function automatic logic is_onehot(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 10; k++) n = n + {3'b000, v[k]};
    return (n == 4'd1);
  endfunction

  function automatic logic [3:0] digit_of(input logic [9:0] v);
    logic [3:0] d;
    d = 4'd0;
    for (int k = 0; k < 10; k++) d = v[k] ? 4'(k) : d;
    return d;
  endfunction

  function automatic logic [EW-1:0] shift_in(input logic [EW-1:0] e, input logic [3:0] d);
    logic [EW-1:0] r;
    r      = e << 4;
    r[3:0] = d;
    return r;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [EW-1:0] entry_r, entry_nxt_s, cap_entry_s, pw_s;
  logic [3:0]    digit_cnt_r, cnt_nxt_s, cap_cnt_s;
  logic [3:0]    fail_cnt_r, fail_nxt_s, fail_inc_s;
  logic          overflow_r, ovf_nxt_s, cap_ovf_s;
  logic [15:0]   timer_r, timer_nxt_s;
  logic          unlock_r, error_r, locked_r, err_nxt_s;
  logic          digit_vld_s, match_s;
  logic [3:0]    digit_s;

  assign digit_vld_s = is_onehot(bus.button_on);
  assign digit_s     = digit_of(bus.button_on);
  assign fail_inc_s  = fail_cnt_r + 4'd1;
  assign match_s     = (digit_cnt_r == PW_LEN_C) && !overflow_r && (entry_r == pw_s);

`ifdef PW_CHANGE_EN
  logic [EW-1:0] pw_r, pw_nxt_s;
  assign pw_s = pw_r;

  // Stored password register, rewritten only by a successful change sequence.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pw_r <= PW_RST;
    end else begin
      pw_r <= pw_nxt_s;
    end
  end
`else
  assign pw_s = PW_RST;
  wire unused_set_pw_s = bus.set_pw;
`endif

  // Effect of accepting a valid digit: shift in while room remains, otherwise poison the entry.
  always_comb begin
    if (digit_cnt_r < PW_LEN_C) begin
      cap_entry_s = shift_in(entry_r, digit_s);
      cap_cnt_s   = digit_cnt_r + 4'd1;
      cap_ovf_s   = overflow_r;
    end else begin
      cap_entry_s = entry_r;
      cap_cnt_s   = digit_cnt_r;
      cap_ovf_s   = 1'b1;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_nxt_s = state_r;
    entry_nxt_s = entry_r;
    cnt_nxt_s   = digit_cnt_r;
    ovf_nxt_s   = overflow_r;
    fail_nxt_s  = fail_cnt_r;
    timer_nxt_s = timer_r;
    err_nxt_s   = 1'b0;
`ifdef PW_CHANGE_EN
    pw_nxt_s    = pw_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (digit_vld_s) begin
          entry_nxt_s = shift_in(entry_r, digit_s);
          cnt_nxt_s   = 4'd1;
          state_nxt_s = ST_ENTRY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (bus.clear) begin
          entry_nxt_s = '0;
          cnt_nxt_s   = 4'd0;
          ovf_nxt_s   = 1'b0;
          state_nxt_s = ST_IDLE;
        end else if (bus.enter) begin
          state_nxt_s = ST_CHECK;
        end else if (digit_vld_s) begin
          entry_nxt_s = cap_entry_s;
          cnt_nxt_s   = cap_cnt_s;
          ovf_nxt_s   = cap_ovf_s;
        end else begin
          state_nxt_s = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        entry_nxt_s = '0;
        cnt_nxt_s   = 4'd0;
        ovf_nxt_s   = 1'b0;
        if (match_s) begin
          fail_nxt_s  = 4'd0;
          timer_nxt_s = UNLOCK_CYCLES;
          state_nxt_s = ST_OPEN;
        end else begin
          err_nxt_s  = 1'b1;
          fail_nxt_s = fail_inc_s;
          if (fail_inc_s == MAX_FAIL_C) begin
            timer_nxt_s = LOCKOUT_CYCLES;
            state_nxt_s = ST_LOCKOUT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
`ifdef PW_CHANGE_EN
        if (bus.set_pw) begin
          state_nxt_s = ST_NEWPW;
        end else
`endif
        if (timer_r == 16'd1) begin
          state_nxt_s = ST_IDLE;
        end else begin
          timer_nxt_s = timer_r - 16'd1;
        end
      end
      ST_LOCKOUT: begin
        if (timer_r == 16'd1) begin
          fail_nxt_s  = 4'd0;
          state_nxt_s = ST_IDLE;
        end else begin
          timer_nxt_s = timer_r - 16'd1;
        end
      end
`ifdef PW_CHANGE_EN
      ST_NEWPW: begin
        if (bus.clear || bus.enter) begin
          if (bus.clear) begin
            pw_nxt_s = pw_r;
          end else if ((digit_cnt_r == PW_LEN_C) && !overflow_r) begin
            pw_nxt_s = entry_r;
          end else begin
            err_nxt_s = 1'b1;
          end
          entry_nxt_s = '0;
          cnt_nxt_s   = 4'd0;
          ovf_nxt_s   = 1'b0;
          state_nxt_s = ST_IDLE;
        end else if (digit_vld_s) begin
          entry_nxt_s = cap_entry_s;
          cnt_nxt_s   = cap_cnt_s;
          ovf_nxt_s   = cap_ovf_s;
        end else begin
          state_nxt_s = ST_NEWPW;
        end
      end
`endif
      default: begin
        entry_nxt_s = '0;
        cnt_nxt_s   = 4'd0;
        ovf_nxt_s   = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; status outputs follow the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      entry_r     <= '0;
      digit_cnt_r <= 4'd0;
      overflow_r  <= 1'b0;
      fail_cnt_r  <= 4'd0;
      timer_r     <= 16'd0;
      unlock_r    <= 1'b0;
      error_r     <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      entry_r     <= entry_nxt_s;
      digit_cnt_r <= cnt_nxt_s;
      overflow_r  <= ovf_nxt_s;
      fail_cnt_r  <= fail_nxt_s;
      timer_r     <= timer_nxt_s;
      unlock_r    <= (state_nxt_s == ST_OPEN);
      error_r     <= err_nxt_s;
      locked_r    <= (state_nxt_s == ST_LOCKOUT);
    end
  end

  assign bus.unlock    = unlock_r;
  assign bus.error     = error_r;
  assign bus.locked    = locked_r;
  assign bus.digit_cnt = digit_cnt_r;
  assign bus.fail_cnt  = fail_cnt_r;
endmodule

// File: tb/tb_doorlock_ctrl.sv
// Directed bench for doorlock_ctrl with small timing parameters (unlock 8, lockout 16, 3 failures).
module tb_doorlock_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks    = 0;
  int   n_errors    = 0;
  int   open_cycles = 0;
  int   lock_cycles = 0;
  int   overlap     = 0;

  doorlock_ctrl_if bus ();

  doorlock_ctrl #(
    .PW_LEN(4), .DEFAULT_PW(32'h0000_1234), .UNLOCK_CYCLES(16'd8),
    .MAX_FAIL(3), .LOCKOUT_CYCLES(16'd16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock edge; observe outputs 1 time unit later.
  task automatic cycle();
    @(posedge clock);
    #1;
    if (bus.unlock) open_cycles++;
    if (bus.locked) lock_cycles++;
    if ((bus.unlock && bus.locked) || (bus.unlock && bus.error)) overlap++;
  endtask

  task automatic press(input int d);
    bus.button_on = 10'(1 << d);
    cycle();
    bus.button_on = 10'd0;
  endtask

  task automatic press4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  // Enter pulse; nothing may show after the first edge, result appears after the second.
  task automatic submit(input string tag);
    bus.enter = 1'b1;
    cycle();
    bus.enter = 1'b0;
    check_val({tag, "_lat1_unlock"}, 32'(bus.unlock), 32'd0);
    check_val({tag, "_lat1_error"}, 32'(bus.error), 32'd0);
    cycle();
  endtask

  task automatic wait_unlock_drop(input string tag);
    int n;
    n = 0;
    while (bus.unlock && n < 100) begin
      cycle();
      n++;
    end
    check_val({tag, "_drop"}, 32'(bus.unlock), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.button_on = 10'd0;
    bus.enter     = 1'b0;
    bus.clear     = 1'b0;
    bus.set_pw    = 1'b0;
    repeat (2) cycle();
    check_val("rst_unlock", 32'(bus.unlock), 32'd0);
    check_val("rst_error", 32'(bus.error), 32'd0);
    check_val("rst_locked", 32'(bus.locked), 32'd0);
    check_val("rst_digits", 32'(bus.digit_cnt), 32'd0);
    check_val("rst_fails", 32'(bus.fail_cnt), 32'd0);
    reset = 1'b1;
    cycle();

    // Correct code opens for exactly 8 cycles.
    press4(1, 2, 3, 4);
    check_val("a_digits", 32'(bus.digit_cnt), 32'd4);
    open_cycles = 0;
    submit("a");
    check_val("a_unlock", 32'(bus.unlock), 32'd1);
    check_val("a_error", 32'(bus.error), 32'd0);
    check_val("a_fails", 32'(bus.fail_cnt), 32'd0);
    wait_unlock_drop("a");
    check_val("a_open_len", 32'(open_cycles), 32'd8);

    // Wrong last digit.
    press4(1, 2, 3, 5);
    submit("b");
    check_val("b_error", 32'(bus.error), 32'd1);
    check_val("b_fails", 32'(bus.fail_cnt), 32'd1);
    check_val("b_unlock", 32'(bus.unlock), 32'd0);
    check_val("b_digits_clr", 32'(bus.digit_cnt), 32'd0);
    cycle();
    check_val("b_err_pulse", 32'(bus.error), 32'd0);

    // Five digits: count saturates, overflow forces a failure.
    press4(1, 2, 3, 4);
    press(5);
    check_val("c_digits_sat", 32'(bus.digit_cnt), 32'd4);
    submit("c");
    check_val("c_error", 32'(bus.error), 32'd1);
    check_val("c_fails", 32'(bus.fail_cnt), 32'd2);
    check_val("c_locked", 32'(bus.locked), 32'd0);

    // Third failure enters a 16-cycle lockout; input is ignored meanwhile.
    press4(9, 9, 9, 9);
    lock_cycles = 0;
    submit("l");
    check_val("l_error", 32'(bus.error), 32'd1);
    check_val("l_locked", 32'(bus.locked), 32'd1);
    check_val("l_fails", 32'(bus.fail_cnt), 32'd3);
    press4(1, 2, 3, 4);
    check_val("l_digits_ign", 32'(bus.digit_cnt), 32'd0);
    submit("l_try");
    check_val("l_try_unlock", 32'(bus.unlock), 32'd0);
    check_val("l_try_locked", 32'(bus.locked), 32'd1);
    for (int i = 0; i < 50 && bus.locked; i++) cycle();
    check_val("l_len", 32'(lock_cycles), 32'd16);
    check_val("l_fails_clr", 32'(bus.fail_cnt), 32'd0);
    press4(1, 2, 3, 4);
    submit("l_after");
    check_val("l_after_unlock", 32'(bus.unlock), 32'd1);
    wait_unlock_drop("l_after");

    // Clear discards an entry; a multi-bit press is no digit.
    press(1); press(2);
    check_val("d_digits2", 32'(bus.digit_cnt), 32'd2);
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    check_val("d_clear", 32'(bus.digit_cnt), 32'd0);
    press(1); press(2);
    bus.button_on = 10'b00_0000_0110;
    cycle();
    bus.button_on = 10'd0;
    check_val("d_multi_ign", 32'(bus.digit_cnt), 32'd2);
    press(3); press(4);
    submit("d");
    check_val("d_unlock", 32'(bus.unlock), 32'd1);
    wait_unlock_drop("d");

    // Enter beats a digit in the same cycle.
    press(1); press(2); press(3);
    bus.button_on = 10'(1 << 4);
    bus.enter     = 1'b1;
    cycle();
    bus.button_on = 10'd0;
    bus.enter     = 1'b0;
    check_val("e_digits", 32'(bus.digit_cnt), 32'd3);
    check_val("e_lat1_error", 32'(bus.error), 32'd0);
    cycle();
    check_val("e_error", 32'(bus.error), 32'd1);
    check_val("e_fails", 32'(bus.fail_cnt), 32'd1);
    check_val("e_unlock", 32'(bus.unlock), 32'd0);

    // Asynchronous reset in the open state.
    press4(1, 2, 3, 4);
    submit("f");
    check_val("f_unlock", 32'(bus.unlock), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("f_rst_unlock", 32'(bus.unlock), 32'd0);
    check_val("f_rst_locked", 32'(bus.locked), 32'd0);
    check_val("f_rst_digits", 32'(bus.digit_cnt), 32'd0);
    check_val("f_rst_fails", 32'(bus.fail_cnt), 32'd0);
    cycle();
    reset = 1'b1;
    cycle();
    check_val("f_post_unlock", 32'(bus.unlock), 32'd0);

`ifdef PW_CHANGE_EN
    // Change the password to 9876 while open.
    press4(1, 2, 3, 4);
    submit("g");
    check_val("g_unlock", 32'(bus.unlock), 32'd1);
    bus.set_pw = 1'b1;
    cycle();
    bus.set_pw = 1'b0;
    check_val("g_setpw_unlock", 32'(bus.unlock), 32'd0);
    press4(9, 8, 7, 6);
    check_val("g_new_digits", 32'(bus.digit_cnt), 32'd4);
    bus.enter = 1'b1;
    cycle();
    bus.enter = 1'b0;
    check_val("g_new_err", 32'(bus.error), 32'd0);
    check_val("g_new_fails", 32'(bus.fail_cnt), 32'd0);
    cycle();
    press4(9, 8, 7, 6);
    submit("g_new");
    check_val("g_new_unlock", 32'(bus.unlock), 32'd1);
    wait_unlock_drop("g_new");
    press4(1, 2, 3, 4);
    submit("g_old");
    check_val("g_old_error", 32'(bus.error), 32'd1);
    check_val("g_old_unlock", 32'(bus.unlock), 32'd0);
`else
    // Without the option, set_pw in the open state changes nothing.
    press4(1, 2, 3, 4);
    submit("g");
    bus.set_pw = 1'b1;
    cycle();
    bus.set_pw = 1'b0;
    check_val("g_setpw_ign", 32'(bus.unlock), 32'd1);
    wait_unlock_drop("g");
`endif

    check_val("exclusive_outputs", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
